// File: rtl/emu_ctrl_pkg.sv
// Shared definitions for the emulator control responder:
// register offsets, AXI response codes, CTRL bit positions.
package emu_ctrl_pkg;

   localparam logic [31:0] ID_VALUE_DEF = 32'h454D5543;

   localparam logic [4:0] OFF_ID      = 5'h00;
   localparam logic [4:0] OFF_CTRL    = 5'h04;
   localparam logic [4:0] OFF_STATUS  = 5'h08;
   localparam logic [4:0] OFF_CMD     = 5'h0C;
   localparam logic [4:0] OFF_SCRATCH = 5'h10;
   localparam logic [4:0] OFF_CYC_LO  = 5'h14;
   localparam logic [4:0] OFF_CYC_HI  = 5'h18;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int CTRL_PAUSE     = 0;
   localparam int CTRL_RESET_REQ = 1;

   function automatic logic [31:0] byte_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/emu_cycle_counter.sv
// Free-running 64-bit cycle counter; a read of the low word
// freezes the high word into a shadow so the pair is coherent.
module emu_cycle_counter (
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   input  logic        lo_rd,
   output logic [63:0] count,
   output logic [31:0] hi_shadow
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count     <= '0;
         hi_shadow <= '0;
      end else begin
         if (en) count <= count + 64'd1;
         if (lo_rd) hi_shadow <= count[63:32];
      end
   end

endmodule

// File: rtl/emu_ctrl_responder.sv
// AXI4-Lite control/status register file for the emulator core.
// Define EMU_CTRL_STRB_EN to honour per-byte write strobes.
module emu_ctrl_responder
   import emu_ctrl_pkg::*;
#(
   parameter int          ADDR_WIDTH = 32,
   parameter logic [31:0] ID_VALUE   = ID_VALUE_DEF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [2:0]            s_axi_awprot,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   input  logic [31:0]           s_axi_wdata,
   input  logic [3:0]            s_axi_wstrb,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   output logic [1:0]            s_axi_bresp,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [2:0]            s_axi_arprot,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [31:0]           s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   input  logic [31:0]           status_in,
   output logic                  ctrl_pause,
   output logic                  ctrl_reset_req,
   output logic [7:0]            cmd_pulse
);

   logic                  live;
   logic                  aw_held;
   logic                  w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;
   logic [1:0]            ctrl_q;
   logic [31:0]           scratch_q;
   logic [63:0]           count;
   logic [31:0]           hi_shadow;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  commit;
   logic [ADDR_WIDTH-1:0] wa;
   logic [31:0]           wd;
   logic [3:0]            ws;
   logic [31:0]           mask;
   logic                  strb_ok;
   logic [4:0]            w_off;
   logic [4:0]            r_off;
   logic                  w_up0;
   logic                  r_up0;
   logic                  wr_ctrl;
   logic                  wr_cmd;
   logic                  wr_scr;
   logic                  wr_ok;
   logic                  lo_rd;
   logic [31:0]           rd_data;
   logic [1:0]            rd_resp;
   logic                  unused;

   // live keeps every ready low until the first edge out of reset
   assign s_axi_awready = live && !aw_held && !s_axi_bvalid;
   assign s_axi_wready  = live && !w_held && !s_axi_bvalid;
   assign s_axi_arready = live && !s_axi_rvalid;

   assign aw_hs  = s_axi_awvalid && s_axi_awready;
   assign w_hs   = s_axi_wvalid && s_axi_wready;
   assign ar_hs  = s_axi_arvalid && s_axi_arready;
   assign commit = (aw_hs || aw_held) && (w_hs || w_held);

   assign wa = aw_held ? aw_addr_q : s_axi_awaddr;
   assign wd = w_held ? w_data_q : s_axi_wdata;
   assign ws = w_held ? w_strb_q : s_axi_wstrb;

   assign w_off = {wa[4:2], 2'b00};
   assign w_up0 = (wa[ADDR_WIDTH-1:5] == '0);
   assign r_off = {s_axi_araddr[4:2], 2'b00};
   assign r_up0 = (s_axi_araddr[ADDR_WIDTH-1:5] == '0);

`ifdef EMU_CTRL_STRB_EN
   assign strb_ok = 1'b1;
   assign mask    = byte_mask(ws);
`else
   assign strb_ok = (ws == 4'hF);
   assign mask    = '1;
`endif

   always_comb begin
      wr_ctrl = 1'b0;
      wr_cmd  = 1'b0;
      wr_scr  = 1'b0;
      if (commit && w_up0 && strb_ok) begin
         unique case (1'b1)
            (w_off == OFF_CTRL):    wr_ctrl = 1'b1;
            (w_off == OFF_CMD):     wr_cmd  = 1'b1;
            (w_off == OFF_SCRATCH): wr_scr  = 1'b1;
            default: ;
         endcase
      end
   end

   assign wr_ok = wr_ctrl || wr_cmd || wr_scr;

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      if (!r_up0) begin
         rd_resp = RESP_SLVERR;
      end else begin
         case (r_off)
            OFF_ID:      rd_data = ID_VALUE;
            OFF_CTRL:    rd_data = {30'd0, ctrl_q};
            OFF_STATUS:  rd_data = status_in;
            OFF_CMD:     rd_data = '0;
            OFF_SCRATCH: rd_data = scratch_q;
            OFF_CYC_LO:  rd_data = count[31:0];
            OFF_CYC_HI:  rd_data = hi_shadow;
            default:     rd_resp = RESP_SLVERR;
         endcase
      end
   end

   assign lo_rd = ar_hs && r_up0 && (r_off == OFF_CYC_LO);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         live      <= 1'b0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         live <= 1'b1;
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_held   <= 1'b1;
               aw_addr_q <= s_axi_awaddr;
            end
            if (w_hs) begin
               w_held   <= 1'b1;
               w_data_q <= s_axi_wdata;
               w_strb_q <= s_axi_wstrb;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         ctrl_q       <= '0;
         scratch_q    <= '0;
         cmd_pulse    <= '0;
      end else begin
         if (commit) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
         if (wr_ctrl)
            ctrl_q <= (ctrl_q & ~mask[1:0]) | (wd[1:0] & mask[1:0]);
         if (wr_scr)
            scratch_q <= (scratch_q & ~mask) | (wd & mask);
         cmd_pulse <= wr_cmd ? (wd[7:0] & mask[7:0]) : 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_axi_rvalid <= 1'b0;
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
      end else if (ar_hs) begin
         s_axi_rvalid <= 1'b1;
         s_axi_rdata  <= rd_data;
         s_axi_rresp  <= rd_resp;
      end else if (s_axi_rready) begin
         s_axi_rvalid <= 1'b0;
      end
   end

   emu_cycle_counter u_cnt (
      .clk       (clk),
      .rstn      (rstn),
      .en        (!ctrl_q[CTRL_PAUSE]),
      .lo_rd     (lo_rd),
      .count     (count),
      .hi_shadow (hi_shadow)
   );

   assign ctrl_pause     = ctrl_q[CTRL_PAUSE];
   assign ctrl_reset_req = ctrl_q[CTRL_RESET_REQ];

   assign unused = ^{s_axi_awprot, s_axi_arprot, wa[1:0], s_axi_araddr[1:0]};

endmodule
